dump_unit: RTL and testbench

Readback stage downstream of the capture unit. After a capture completes, the host issues a dump command. This block then reads one channel's circular sample RAM in chronological order, starting at the oldest entry (the capture unit's final write address) and wrapping at ENTRIES. Each byte is handed to the UART transmitter with a trmt/tx_done handshake.

---
 rtl/dump_unit.sv | 120 ++++++++++++
 tb/tb_dump_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dump_unit.sv
// dump_unit: replays one channel's circular sample RAM, oldest entry first, to the UART.
// Latency: first trmt 3 cycles after dump_start (header byte after 1 cycle when DUMP_HDR_EN is defined).
// Backpressure: one byte in flight; the next RAM read waits for tx_done of the previous byte.
module dump_unit #(
   parameter int ENTRIES = 384,
   parameter int LOG2    = 9
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dump_start,
   input  logic [2:0]      dump_ch,
   input  logic [LOG2-1:0] waddr,
   input  logic [7:0]      rdata,
   input  logic            tx_done,
   output logic [2:0]      ch_sel,
   output logic            ren,
   output logic [LOG2-1:0] raddr,
   output logic [7:0]      tx_data,
   output logic            trmt,
   output logic            busy,
   output logic            dump_done
);

   // Byte count is one bit wider than the address so that ENTRIES itself fits.
   localparam logic [LOG2:0]   ENT_CNT   = (LOG2+1)'(ENTRIES);
   localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
`ifdef DUMP_HDR_EN
      S_HDR     = 3'd1,
`endif
      S_RD      = 3'd2,
      S_LATCH   = 3'd3,
      S_WAIT_TX = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t          state, nxt;
   logic [LOG2-1:0] rd_ptr;
   logic [LOG2-1:0] raddr_q;
   logic [LOG2:0]   byte_cnt;

   // State register; reset drops any dump in progress without a dump_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   // Next-state logic; dump_start is only looked at in IDLE, tx_done only while a byte is out.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: begin
            if (dump_start) begin
`ifdef DUMP_HDR_EN
               nxt = S_HDR;
`else
               nxt = S_RD;
`endif
            end
         end
`ifdef DUMP_HDR_EN
         S_HDR:     if (tx_done) nxt = S_RD;
`endif
         S_RD:      nxt = S_LATCH;
         S_LATCH:   nxt = S_WAIT_TX;
         S_WAIT_TX: begin
            if (tx_done) nxt = (byte_cnt == ENT_CNT) ? S_DONE : S_RD;
         end
         S_DONE:    nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase
   end

   // State-decoded outputs; raddr keeps the last read address outside RD.
   always_comb begin
      ren       = (state == S_RD);
      busy      = (state != S_IDLE);
      dump_done = (state == S_DONE);
      raddr     = (state == S_RD) ? rd_ptr : raddr_q;
   end

   // Datapath: channel/pointer capture on start, byte latch and pointer advance per sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_sel   <= '0;
         rd_ptr   <= '0;
         raddr_q  <= '0;
         byte_cnt <= '0;
         tx_data  <= '0;
         trmt     <= 1'b0;
      end else begin
         trmt <= 1'b0;
         case (state)
            S_IDLE: begin
               if (dump_start) begin
                  ch_sel   <= dump_ch;
                  // An out-of-range write address can only mean the RAM never wrapped; start at 0.
                  rd_ptr   <= ({1'b0, waddr} >= ENT_CNT) ? '0 : waddr;
                  byte_cnt <= '0;
`ifdef DUMP_HDR_EN
                  tx_data  <= {5'b10100, dump_ch};
                  trmt     <= 1'b1;
`endif
               end
            end
            S_RD: raddr_q <= rd_ptr;
            S_LATCH: begin
               tx_data  <= rdata;
               trmt     <= 1'b1;
               rd_ptr   <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
               byte_cnt <= byte_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dump_unit.sv
// Directed bench for dump_unit with an 8-entry RAM model and a UART stub
// that answers every trmt with tx_done four cycles later.
// Build with DUMP_HDR_EN defined to cover the header byte.
module tb_dump_unit;
   localparam int ENTRIES = 8;
   localparam int LOG2    = 4;
`ifdef DUMP_HDR_EN
   localparam int HDR    = 1;
   localparam int RD_CYC = 6;
`else
   localparam int HDR    = 0;
   localparam int RD_CYC = 1;
`endif

   logic            clk;
   logic            rst_n;
   logic            dump_start;
   logic [2:0]      dump_ch;
   logic [LOG2-1:0] waddr;
   logic [7:0]      rdata;
   logic            tx_auto = 1'b0;
   logic            tx_spur;
   logic            tx_done;
   logic [2:0]      ch_sel;
   logic            ren;
   logic [LOG2-1:0] raddr;
   logic [7:0]      tx_data;
   logic            trmt;
   logic            busy;
   logic            dump_done;

   assign tx_done = tx_auto | tx_spur;

   dump_unit #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
      .clk(clk), .rst_n(rst_n), .dump_start(dump_start), .dump_ch(dump_ch),
      .waddr(waddr), .rdata(rdata), .tx_done(tx_done), .ch_sel(ch_sel),
      .ren(ren), .raddr(raddr), .tx_data(tx_data), .trmt(trmt),
      .busy(busy), .dump_done(dump_done)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int trmt_cnt = 0;
   int ren_cnt  = 0;
   int done_cnt = 0;
   int bad_addr = 0;
   int cd       = 0;
   logic [7:0] tx_log[$];
   logic [7:0] ram[16];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = (i < ENTRIES) ? 8'(8'h10 + i) : 8'hEE;
   end

   // Synchronous-read RAM model: data the cycle after ren.
   always @(posedge clk) if (ren) rdata <= ram[raddr];

   // Monitor and UART stub, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         cd      = 0;
         tx_auto = 1'b0;
      end else begin
         tx_auto = 1'b0;
         if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) tx_auto = 1'b1;
         end
         if (trmt) begin
            tx_log.push_back(tx_data);
            trmt_cnt++;
            cd = 4;
         end
         if (ren) begin
            ren_cnt++;
            if (int'(raddr) >= ENTRIES) bad_addr++;
         end
         if (dump_done) done_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [2:0] ch, input logic [LOG2-1:0] wa);
      dump_ch    = ch;
      waddr      = wa;
      dump_start = 1'b1;
      cyc();
      dump_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 2000) begin
         cyc();
         n++;
      end
      chk(tag, {31'd0, busy}, 0);
   endtask

   task automatic check_dump(input int tb_base, input int ren_base, input int done_base,
                             input logic [2:0] ch, input int wa_eff);
      logic [7:0] got;
      int idx;
      chk("trmt_count", trmt_cnt - tb_base, ENTRIES + HDR);
      chk("ren_count", ren_cnt - ren_base, ENTRIES);
      chk("done_count", done_cnt - done_base, 1);
      chk("raddr_range", bad_addr, 0);
      chk("busy_after", {31'd0, busy}, 0);
`ifdef DUMP_HDR_EN
      got = (tb_base < tx_log.size()) ? tx_log[tb_base] : 8'hEE;
      chk("hdr_byte", {24'd0, got}, {24'd0, 5'b10100, ch});
`endif
      for (int i = 0; i < ENTRIES; i++) begin
         idx = tb_base + HDR + i;
         got = (idx < tx_log.size()) ? tx_log[idx] : 8'hEE;
         chk($sformatf("byte%0d", i), {24'd0, got}, 32'h10 + ((wa_eff + i) % ENTRIES));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, r, d, n;
      rst_n = 1'b0; dump_start = 1'b0; dump_ch = 3'd0; waddr = '0; tx_spur = 1'b0;
      repeat (3) cyc();
      chk("rst_ch_sel", {29'd0, ch_sel}, 0);
      chk("rst_ren", {31'd0, ren}, 0);
      chk("rst_raddr", {28'd0, raddr}, 0);
      chk("rst_tx_data", {24'd0, tx_data}, 0);
      chk("rst_trmt", {31'd0, trmt}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_dump_done", {31'd0, dump_done}, 0);
      rst_n = 1'b1;
      cyc();

      // Spurious tx_done in IDLE must not start anything.
      tx_spur = 1'b1; cyc(); tx_spur = 1'b0; cyc();
      chk("idle_spur_busy", {31'd0, busy}, 0);
      chk("idle_spur_trmt", trmt_cnt, 0);

      // Dump from waddr=5: wrap order and first-byte timing.
      b = trmt_cnt; r = ren_cnt; d = done_cnt;
      start(3'd0, 4'd5);
      chk("c1_busy", {31'd0, busy}, 1);
`ifdef DUMP_HDR_EN
      chk("c1_hdr_trmt", {31'd0, trmt}, 1);
      chk("c1_hdr_data", {24'd0, tx_data}, 32'hA0);
      chk("c1_ren", {31'd0, ren}, 0);
`else
      chk("c1_ren", {31'd0, ren}, 1);
      chk("c1_raddr", {28'd0, raddr}, 5);
      cyc(); cyc();
      chk("c3_trmt", {31'd0, trmt}, 1);
      chk("c3_tx_data", {24'd0, tx_data}, 32'h15);
      cyc();
      chk("c4_trmt", {31'd0, trmt}, 0);
`endif
      wait_idle("t1_idle");
      check_dump(b, r, d, 3'd0, 5);

      // waddr=0: straight order.
      b = trmt_cnt; r = ren_cnt; d = done_cnt;
      start(3'd0, 4'd0);
      wait_idle("t2_idle");
      check_dump(b, r, d, 3'd0, 0);

      // waddr beyond ENTRIES starts from 0.
      b = trmt_cnt; r = ren_cnt; d = done_cnt;
      start(3'd0, 4'd12);
      wait_idle("t2b_idle");
      check_dump(b, r, d, 3'd0, 0);

      // Second dump_start mid-dump is ignored.
      b = trmt_cnt; r = ren_cnt; d = done_cnt;
      start(3'd1, 4'd2);
      repeat (20) cyc();
      dump_ch = 3'd3; dump_start = 1'b1; cyc(); dump_start = 1'b0;
      chk("mid_ch_sel", {29'd0, ch_sel}, 1);
      wait_idle("t3_idle");
      chk("end_ch_sel", {29'd0, ch_sel}, 1);
      check_dump(b, r, d, 3'd1, 2);

      // Reset after the third byte, then a clean dump.
      b = trmt_cnt;
      start(3'd2, 4'd4);
      n = 0;
      while (trmt_cnt - b < 3 + HDR && n < 500) begin cyc(); n++; end
      chk("pre_rst_bytes", trmt_cnt - b, 3 + HDR);
      cyc();
      rst_n = 1'b0;
      #1;
      chk("mrst_ch_sel", {29'd0, ch_sel}, 0);
      chk("mrst_ren", {31'd0, ren}, 0);
      chk("mrst_raddr", {28'd0, raddr}, 0);
      chk("mrst_tx_data", {24'd0, tx_data}, 0);
      chk("mrst_trmt", {31'd0, trmt}, 0);
      chk("mrst_busy", {31'd0, busy}, 0);
      chk("mrst_dump_done", {31'd0, dump_done}, 0);
      d = done_cnt;
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (20) cyc();
      chk("mrst_no_done", done_cnt - d, 0);
      b = trmt_cnt; r = ren_cnt; d = done_cnt;
      start(3'd2, 4'd4);
      wait_idle("t4_idle");
      check_dump(b, r, d, 3'd2, 4);

      // Spurious tx_done while in RD.
      b = trmt_cnt; r = ren_cnt; d = done_cnt;
      start(3'd0, 4'd1);
      repeat (RD_CYC - 1) cyc();
      chk("spur_in_rd", {31'd0, ren}, 1);
      tx_spur = 1'b1; cyc(); tx_spur = 1'b0;
      chk("spur_latch_ren", {31'd0, ren}, 0);
      chk("spur_latch_trmt", {31'd0, trmt}, 0);
      cyc();
      chk("spur_trmt", {31'd0, trmt}, 1);
      chk("spur_tx_data", {24'd0, tx_data}, 32'h11);
      wait_idle("t5_idle");
      check_dump(b, r, d, 3'd0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
